data_mem_ctrl: RTL and testbench

Parametrised data-memory controller for the MIPS core, replacing the fixed single-cycle data RAM hookup at the top level. It owns the data memory array and serves one load or store at a time with a configurable number of wait states, using a req/ready handshake that stalls the core. It supports byte, half-word and word accesses with byte-lane stores and sign/zero-extended loads. Misalignment and range checking are a build option.

---
 rtl/data_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores with LATENCY wait states.
// Optional `DMEM_ADDR_CHECK_EN enables misalignment/range rejection via addr_err.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        addr_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               ready_nx, err_nx;
    logic [31:0]        rdata_nx;

    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-1:0]  idx_c;
    logic [1:0]         off_c;
    logic [3:0]         be_c;
    logic [31:0]        wlane_c, word_c, load_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic               access_ok_c, mem_we_c;

    assign idx_c  = addr[ADDR_W+1:2];
    assign word_c = mem[idx_c];
    assign stall  = req & ~ready;

`ifdef DMEM_ADDR_CHECK_EN
    assign access_ok_c = !((size == 2'b11) ||
                           (size == 2'b01 && addr[0]) ||
                           (size == 2'b10 && addr[1:0] != 2'b00) ||
                           (addr[31:ADDR_W+2] != '0));
`else
    // Upper address bits are don't-care when wrapping modulo depth.
    logic unused_addr_c;
    assign unused_addr_c = ^addr[31:ADDR_W+2];
    assign access_ok_c   = 1'b1;
`endif

    // Lane offset (forced aligned), byte enables and replicated store data.
    always_comb begin
        off_c   = 2'b00;
        be_c    = 4'b1111;
        wlane_c = wdata;
        case (size)
            2'b00: begin
                off_c   = addr[1:0];
                be_c    = 4'b0001 << off_c;
                wlane_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                off_c   = {addr[1], 1'b0};
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wlane_c = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        case (off_c)
            2'd0:    byte_c = word_c[7:0];
            2'd1:    byte_c = word_c[15:8];
            2'd2:    byte_c = word_c[23:16];
            default: byte_c = word_c[31:24];
        endcase
        half_c = off_c[1] ? word_c[31:16] : word_c[15:0];
        case (size)
            2'b00:   load_c = {{24{sign_ext & byte_c[7]}}, byte_c};
            2'b01:   load_c = {{16{sign_ext & half_c[15]}}, half_c};
            default: load_c = word_c;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ready_nx = 1'b0;
        err_nx   = 1'b0;
        rdata_nx = rdata;
        mem_we_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (access_ok_c) begin
                        state_nx = S_WAIT;
                        cnt_nx   = CNT_W'(LATENCY);
                    end else begin
                        state_nx = S_RESP;
                        ready_nx = 1'b1;
                        err_nx   = 1'b1;
                        rdata_nx = '0;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    state_nx = S_RESP;
                    mem_we_c = we;
                    ready_nx = 1'b1;
                    rdata_nx = we ? 32'h0 : load_c;
                end
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ready    <= 1'b0;
            addr_err <= 1'b0;
            rdata    <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            ready    <= ready_nx;
            addr_err <= err_nx;
            rdata    <= rdata_nx;
        end
    end

    // Array has no reset; written only on the completing WAIT edge.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem[idx_c][8*b +: 8] <= wlane_c[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed cases plus random accesses against a byte-array model.
module tb_data_mem_ctrl;

    localparam int unsigned AW    = 10;
    localparam int          LAT   = 2;
    localparam int          BYTES = 4 * (2 ** AW);

    logic        clk, rst;
    logic        req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        ready, stall, addr_err;

    logic        z_req, z_we, z_sext;
    logic [1:0]  z_size;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic        z_ready, z_stall, z_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mbytes [0:BYTES-1];

    data_mem_ctrl #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .stall(stall),
        .addr_err(addr_err)
    );

    data_mem_ctrl #(.ADDR_W(AW), .LATENCY(0)) u_dut_z (
        .clk(clk), .rst(rst), .req(z_req), .we(z_we), .size(z_size), .sign_ext(z_sext),
        .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata), .ready(z_ready), .stall(z_stall),
        .addr_err(z_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: little-endian byte array, accesses of 1/2/4 bytes.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int eff_addr(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'(nbytes(sz) - 1);
        return int'(b % 32'(BYTES));
    endfunction

    function automatic bit model_legal(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
        return (sz != 2'b11) && ((a % 32'(nbytes(sz))) == 0) && (a < 32'(BYTES));
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [31:0] a,
                                        input logic [31:0] wd);
        int ea;
        ea = eff_addr(sz, a);
        for (int i = 0; i < nbytes(sz); i++) mbytes[ea + i] = wd[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic se,
                                               input logic [31:0] a);
        int          ea, n;
        logic [31:0] v;
        ea = eff_addr(sz, a);
        n  = nbytes(sz);
        v  = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[ea + i];
        if (se && n < 4 && v[8*n-1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    // Drive one access from an IDLE cycle; returns edges-to-ready (-1 on timeout) and leaves bus idle.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic se,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er, output int lat);
        req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = wd;
        lat = -1; rd = 'x; er = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = k; rd = rdata; er = addr_err;
                break;
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else n_pass++;
        n_checks++; if (addr_err !== 1'b0) $display("FAIL reset_err: got %b want 0", addr_err); else n_pass++;
        n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall_lo: got %b want 0", stall); else n_pass++;
        req = 1'b1; #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL reset_stall_hi: got %b want 1", stall); else n_pass++;
        req = 1'b0;
    endtask

    task automatic test_basic();
        logic        t_we   [10] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        logic [1:0]  t_sz   [10] = '{2, 2, 0, 2, 0, 0, 1, 1, 1, 2};
        logic        t_se   [10] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        logic [31:0] t_addr [10] = '{32'h10, 32'h10, 32'h13, 32'h10, 32'h13,
                                     32'h13, 32'h12, 32'h12, 32'h12, 32'h10};
        logic [31:0] t_wd   [10] = '{32'h12345678, 0, 32'h555555AB, 0, 0,
                                     0, 32'h77778001, 0, 0, 0};
        logic [31:0] t_exp  [10] = '{0, 32'h12345678, 0, 32'hAB345678, 32'hFFFFFFAB,
                                     32'h000000AB, 0, 32'hFFFF8001, 32'h00008001, 32'h80015678};
        logic [31:0] rd;
        logic        er;
        int          lat;
        for (int w = 0; w < 16; w++) begin
            logic [31:0] v;
            v = $urandom;
            do_access(1'b1, 2'b10, 1'b0, 32'(4 * w), v, rd, er, lat);
            model_store(2'b10, 32'(4 * w), v);
        end
        for (int i = 0; i < 10; i++) begin
            do_access(t_we[i], t_sz[i], t_se[i], t_addr[i], t_wd[i], rd, er, lat);
            if (t_we[i]) model_store(t_sz[i], t_addr[i], t_wd[i]);
            n_checks++; if (lat !== LAT + 2) $display("FAIL basic_lat[%0d]: got %0d want %0d", i, lat, LAT + 2); else n_pass++;
            n_checks++; if (rd !== t_exp[i]) $display("FAIL basic_rdata[%0d]: got %h want %h", i, rd, t_exp[i]); else n_pass++;
            n_checks++; if (er !== 1'b0) $display("FAIL basic_err[%0d]: got %b want 0", i, er); else n_pass++;
        end
    endtask

    task automatic test_addr_check();
        logic [31:0] rd;
        logic        er;
        int          lat;
`ifdef DMEM_ADDR_CHECK_EN
        do_access(1'b0, 2'b10, 1'b0, 32'h11, 0, rd, er, lat);
        n_checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) $display("FAIL chk_misalign: lat %0d err %b rdata %h want 1 1 0", lat, er, rd); else n_pass++;
        do_access(1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFEF00D, rd, er, lat);
        n_checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) $display("FAIL chk_range: lat %0d err %b rdata %h want 1 1 0", lat, er, rd); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er, lat);
        n_checks++; if (rd !== model_load(2'b10, 1'b0, 32'h0)) $display("FAIL chk_unchanged0: got %h want %h", rd, model_load(2'b10, 1'b0, 32'h0)); else n_pass++;
        do_access(1'b0, 2'b11, 1'b0, 32'h10, 0, rd, er, lat);
        n_checks++; if (lat !== 1 || er !== 1'b1) $display("FAIL chk_size11: lat %0d err %b want 1 1", lat, er); else n_pass++;
`else
        do_access(1'b0, 2'b10, 1'b0, 32'h11, 0, rd, er, lat);
        n_checks++; if (rd !== 32'h80015678 || er !== 1'b0) $display("FAIL wrap_misalign: rdata %h err %b want 80015678 0", rd, er); else n_pass++;
        do_access(1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFEF00D, rd, er, lat);
        model_store(2'b10, 32'h1000, 32'hCAFEF00D);
        n_checks++; if (lat !== LAT + 2 || er !== 1'b0) $display("FAIL wrap_store: lat %0d err %b want %0d 0", lat, er, LAT + 2); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er, lat);
        n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL wrap_load0: got %h want cafef00d", rd); else n_pass++;
        do_access(1'b0, 2'b11, 1'b1, 32'h12, 0, rd, er, lat);
        n_checks++; if (rd !== 32'h80015678) $display("FAIL wrap_size11: got %h want 80015678", rd); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd, exp;
        logic        er;
        int          lat;
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 0, rd, er, lat);
        exp = model_load(2'b10, 1'b0, 32'h20);
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h20; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        n_checks++; if (ready !== 1'b0 || addr_err !== 1'b0 || rdata !== 32'h0) $display("FAIL rstwait_outs: ready %b err %b rdata %h want 0 0 0", ready, addr_err, rdata); else n_pass++;
        req = 1'b0; #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_access(1'b0, 2'b10, 1'b0, 32'h20, 0, rd, er, lat);
        n_checks++; if (rd !== exp) $display("FAIL rstwait_mem: got %h want %h", rd, exp); else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] rd, exp;
        logic        er;
        int          lat, seen;
        exp = model_load(2'b10, 1'b0, 32'h24);
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h24; wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL abort_ready: got %0d pulses want 0", seen); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 32'h24, 0, rd, er, lat);
        n_checks++; if (rd !== exp) $display("FAIL abort_mem: got %h want %h", rd, exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, v;
        logic        er;
        int          lat;
        v = $urandom;
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; wdata = 0;
        #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL b2b_stall_req: got %b want 1", stall); else n_pass++;
        lat = -1; rd = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ready) begin lat = k; rd = rdata; break; end
        end
        n_checks++; if (lat !== LAT + 2) $display("FAIL b2b_lat_a: got %0d want %0d", lat, LAT + 2); else n_pass++;
        n_checks++; if (rd !== model_load(2'b10, 1'b0, 32'h10)) $display("FAIL b2b_rdata_a: got %h want %h", rd, model_load(2'b10, 1'b0, 32'h10)); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL b2b_stall_ready: got %b want 0", stall); else n_pass++;
        we = 1'b1; addr = 32'h28; wdata = v;
        lat = -1; rd = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ready) begin lat = k; rd = rdata; break; end
        end
        model_store(2'b10, 32'h28, v);
        n_checks++; if (lat !== LAT + 3) $display("FAIL b2b_lat_b: got %0d want %0d", lat, LAT + 3); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL b2b_store_rdata: got %h want 0", rd); else n_pass++;
        req = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ready !== 1'b0) $display("FAIL b2b_pulse: got %b want 0", ready); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 32'h28, 0, rd, er, lat);
        n_checks++; if (rd !== v) $display("FAIL b2b_mem: got %h want %h", rd, v); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp;
        logic [1:0]  sz;
        logic        w, se, er, legal;
        int          lat, elat;
        for (int i = 0; i < 150; i++) begin
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
            sz = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            se = 1'($urandom_range(0, 1));
            wd = $urandom;
            legal = model_legal(sz, a);
            exp   = (!legal || w) ? 32'h0 : model_load(sz, se, a);
            elat  = legal ? LAT + 2 : 1;
            do_access(w, sz, se, a, wd, rd, er, lat);
            if (legal && w) model_store(sz, a, wd);
            n_checks++; if (lat !== elat) $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, elat); else n_pass++;
            n_checks++; if (rd !== exp) $display("FAIL rand_rdata[%0d]: a %h sz %0d we %b se %b got %h want %h", i, a, sz, w, se, rd, exp); else n_pass++;
            n_checks++; if (er !== !legal) $display("FAIL rand_err[%0d]: got %b want %b", i, er, !legal); else n_pass++;
        end
    endtask

    task automatic test_latency_zero();
        int lat;
        z_req = 1'b1; z_we = 1'b1; z_size = 2'b10; z_sext = 1'b0; z_addr = 32'h40; z_wdata = 32'hA5A55A5A;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (z_ready) begin lat = k; break; end
        end
        n_checks++; if (lat !== 2) $display("FAIL lat0_store: got %0d want 2", lat); else n_pass++;
        n_checks++; if (z_rdata !== 32'h0) $display("FAIL lat0_store_rdata: got %h want 0", z_rdata); else n_pass++;
        z_req = 1'b0;
        @(posedge clk); #1;
        z_req = 1'b1; z_we = 1'b0; z_size = 2'b01; z_sext = 1'b1; z_addr = 32'h42;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (z_ready) begin lat = k; break; end
        end
        n_checks++; if (lat !== 2) $display("FAIL lat0_load: got %0d want 2", lat); else n_pass++;
        n_checks++; if (z_rdata !== 32'hFFFFA5A5 || z_err !== 1'b0) $display("FAIL lat0_rdata: got %h err %b want ffffa5a5 0", z_rdata, z_err); else n_pass++;
        z_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
        z_req = 1'b0; z_we = 1'b0; z_size = 2'b00; z_sext = 1'b0; z_addr = '0; z_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_addr_check();
        test_reset_mid_wait();
        test_abort();
        test_back_to_back();
        test_random();
        test_latency_zero();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
